// File: rtl/pll_lock_supervisor_pkg.sv
//==============================================================================
// Module : pll_lock_supervisor_pkg
// Brief  : Shared state encodings and helpers for the PLL lock supervisor.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pll_lock_supervisor_pkg;

    // Supervisor FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POWERDOWN = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } sup_state_e;

    // The PLL is released from powerdown only while we wait for, qualify or use lock
    function automatic logic pll_released(input sup_state_e s);
        return (s == S_WAIT_LOCK) || (s == S_STABLE) || (s == S_RUN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_sync.sv
//==============================================================================
// Module : pll_lock_sync
// Brief  : Two-flop synchronizer bringing the raw PLL lock into the ref clock.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; both stages clear to "not locked" on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
//==============================================================================
// Module : pll_lock_supervisor
// Brief  : Sequences CCC PLL power-up, qualifies lock, declares clocks ready,
//          retries on timeout / lock loss and latches a fault after the
//          allowed number of retries. Runs on the free-running ref clock.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned CNT_W              = 24,
    parameter int unsigned PWRDN_CYCLES       = 100,
    parameter int unsigned LOCK_TIMEOUT       = 5000000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned RETRY_W            = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               clear_fault_i,
    input  logic               pll_lock_i,
    output logic               pll_powerdown_n_o,
    output logic               clk_ready_o,
    output logic               lock_lost_o,
    output logic               fault_o,
    output logic [RETRY_W-1:0] retry_count_o
);

    // Terminal counts: each state leaves on the cycle its count reaches limit-1
    localparam logic [CNT_W-1:0]   PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    sup_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pwrdn_n_q;
    logic               clk_ready_q;
    logic               lock_lost_q, lock_lost_d;
    logic               fault_q;
    logic               lock_s;

    pll_lock_sync u_lock_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (pll_lock_i),
        .sync_o  (lock_s)
    );

    // Next-state, counter and retry bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_POWERDOWN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_POWERDOWN: begin
                if (cnt_q == PWRDN_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // Lock arriving in the timeout cycle takes priority over the retry
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_POWERDOWN;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Lock loss re-sequences the PLL without consuming a retry
                if (!lock_s) begin
                    state_d     = S_POWERDOWN;
                    cnt_d       = '0;
                    lock_lost_d = 1'b1;
                end
            end
            S_FAULT: begin
                if (clear_fault_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Dropping enable abandons any bring-up; only a fault survives it
        if (!enable_i && (state_q != S_FAULT)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            retry_d = retry_q;
        end
    end

    // State, counter and all outputs update on the same edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            pwrdn_n_q   <= 1'b0;
            clk_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pwrdn_n_q   <= pll_released(state_d);
            clk_ready_q <= (state_d == S_RUN);
            lock_lost_q <= lock_lost_d;
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign pll_powerdown_n_o = pwrdn_n_q;
    assign clk_ready_o       = clk_ready_q;
    assign lock_lost_o       = lock_lost_q;
    assign fault_o           = fault_q;
    assign retry_count_o     = retry_q;

endmodule

`default_nettype wire
